// File: rtl/trng_ro_ctrl.sv
// rtl/trng_ro_ctrl.sv - ring-oscillator TRNG sequencer: warm-up, decimation, repetition-count test, word handshake
module trng_ro_ctrl #(
    parameter int WIDTH     = 32,
    parameter int WARMUP    = 256,
    parameter int DECIM     = 4,
    parameter int RCT_LIMIT = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_rand_in,
    output logic             o_ro_rst,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_fail
);

    localparam int WW = $clog2(WARMUP + 1);
    localparam int DW = $clog2(DECIM + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(RCT_LIMIT + 1);

    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [RW-1:0] RUN_LIMIT = RW'(RCT_LIMIT);
    localparam logic [RW-1:0] RUN_ONE   = RW'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WARMUP  = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;

    logic [2:0]       r_state;
    logic [WW-1:0]    r_warm_cnt;
    logic [DW-1:0]    r_dec_cnt;
    logic [BW-1:0]    r_bit_cnt;
    logic [RW-1:0]    r_run_cnt;
    logic             r_last;
    logic [WIDTH-1:0] r_sreg;

    logic          w_sample;
    logic [RW-1:0] w_run_next;
    logic          w_rct_trip;
    logic          w_word_done;

    // A run count of zero marks the first sample since the session started.
    always_comb begin
        w_sample    = (r_state == S_COLLECT) && !i_stop && (r_dec_cnt == DEC_LAST);
        w_run_next  = ((r_run_cnt == '0) || (i_rand_in != r_last)) ? RUN_ONE : (r_run_cnt + 1'b1);
        w_rct_trip  = w_sample && (w_run_next == RUN_LIMIT);
        w_word_done = w_sample && (r_bit_cnt == BIT_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_warm_cnt <= '0;
            r_dec_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_run_cnt  <= '0;
            r_last     <= 1'b0;
            r_sreg     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_warm_cnt <= '0;
                    r_dec_cnt  <= '0;
                    r_bit_cnt  <= '0;
                    r_run_cnt  <= '0;
                    if (i_start) begin
                        r_state <= S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (r_warm_cnt == WARM_LAST) begin
                        r_state   <= S_COLLECT;
                        r_dec_cnt <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? '0 : (r_dec_cnt + 1'b1);
                        if (w_sample) begin
                            r_sreg    <= {r_sreg[WIDTH-2:0], i_rand_in};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_run_cnt <= w_run_next;
                            r_last    <= i_rand_in;
                        end
                        // A tripped health test wins over a completed word.
                        if (w_rct_trip) begin
                            r_state <= S_FAIL;
                        end else if (w_word_done) begin
                            r_state   <= S_HOLD;
                            r_dec_cnt <= '0;
                        end
                    end
                end
                S_HOLD: begin
                    r_dec_cnt <= '0;
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (i_ready) begin
                        r_state   <= S_COLLECT;
                        r_bit_cnt <= '0;
                    end
                end
                S_FAIL: begin
                    r_state <= S_FAIL;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_ro_rst = (r_state == S_IDLE) || (r_state == S_FAIL);
        o_busy   = (r_state == S_WARMUP) || (r_state == S_COLLECT) || (r_state == S_HOLD);
        o_valid  = (r_state == S_HOLD);
        o_fail   = (r_state == S_FAIL);
        o_word   = r_sreg;
    end

endmodule

// File: tb/tb_trng_ro_ctrl.sv
// tb/tb_trng_ro_ctrl.sv - self-checking bench for trng_ro_ctrl against a cycle-level behavioural model
module tb_trng_ro_ctrl;

    localparam int W  = 8;
    localparam int WU = 16;
    localparam int D  = 2;
    localparam int RL = 6;

    localparam int M_IDLE = 0;
    localparam int M_WARM = 1;
    localparam int M_COLL = 2;
    localparam int M_HOLD = 3;
    localparam int M_FAIL = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         rand_in = 1'b0;
    logic         ready = 1'b0;
    logic         ro_rst;
    logic         busy;
    logic [W-1:0] word;
    logic         valid;
    logic         fail;

    trng_ro_ctrl #(.WIDTH(W), .WARMUP(WU), .DECIM(D), .RCT_LIMIT(RL)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_stop   (stop),
        .i_rand_in(rand_in),
        .o_ro_rst (ro_rst),
        .o_busy   (busy),
        .o_word   (word),
        .o_valid  (valid),
        .i_ready  (ready),
        .o_fail   (fail)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;
    int t0    = 0;

    // Behavioural model: mode, elapsed warm-up cycles, cycles spent collecting, run length, bits of the current word.
    int m_mode    = M_IDLE;
    int m_elapsed = 0;
    int m_n       = 0;
    int m_run     = 0;
    bit m_last    = 1'b0;
    bit m_sampled = 1'b0;
    bit m_bits[$];

    bit src_q[$];
    bit stuck_en  = 1'b0;
    bit stuck_val = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model_word();
        logic [W-1:0] w;
        w = '0;
        foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
        return w;
    endfunction

    task automatic model_step();
        m_sampled = 1'b0;
        if (rst) begin
            m_mode = M_IDLE;
            m_run  = 0;
            m_last = 1'b0;
            m_bits.delete();
            return;
        end
        case (m_mode)
            M_IDLE: if (start) begin
                m_mode    = M_WARM;
                m_elapsed = 0;
                m_run     = 0;
            end
            M_WARM: if (stop) m_mode = M_IDLE;
            else begin
                m_elapsed++;
                if (m_elapsed == WU) begin
                    m_mode = M_COLL;
                    m_n    = 0;
                    m_bits.delete();
                end
            end
            M_COLL: if (stop) m_mode = M_IDLE;
            else begin
                m_n++;
                if (m_n % D == 0) begin
                    m_sampled = 1'b1;
                    if (m_run == 0 || rand_in != m_last) m_run = 1;
                    else m_run++;
                    m_last = rand_in;
                    m_bits.push_back(rand_in);
                    if (m_run >= RL) m_mode = M_FAIL;
                    else if (m_bits.size() == W) m_mode = M_HOLD;
                end
            end
            M_HOLD: if (stop) m_mode = M_IDLE;
            else if (ready) begin
                m_mode = M_COLL;
                m_n    = 0;
                m_bits.delete();
            end
            default: ;
        endcase
    endtask

    task automatic drive_rand();
        if (src_q.size() > 0) rand_in = src_q[0];
        else if (stuck_en) rand_in = stuck_val;
        else rand_in = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        if (m_sampled && src_q.size() > 0) void'(src_q.pop_front());
        #1;
        cyc++;
        chk("ro_rst", 32'(ro_rst), 32'(m_mode == M_IDLE || m_mode == M_FAIL));
        chk("busy", 32'(busy), 32'(m_mode == M_WARM || m_mode == M_COLL || m_mode == M_HOLD));
        chk("valid", 32'(valid), 32'(m_mode == M_HOLD));
        chk("fail", 32'(fail), 32'(m_mode == M_FAIL));
        if (m_mode == M_HOLD) chk("word", 32'(word), 32'(model_word()));
        drive_rand();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; ready = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        src_q.delete();
        stuck_en = 1'b0;
        drive_rand();
    endtask

    task automatic fill_alt(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(bit'((i % 2) == 0));
        drive_rand();
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) src_q.push_back(b[i]);
        drive_rand();
    endtask

    task automatic pulse_start();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !valid; i++) tick();
    endtask

    task automatic wait_fail(input int budget);
        for (int i = 0; i < budget && !fail; i++) tick();
    endtask

    initial begin
        logic [W-1:0] held;
        int accepted;

        // Reset with random inputs on every pin.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom_range(0, 1));
            stop  = 1'($urandom_range(0, 1));
            ready = 1'($urandom_range(0, 1));
            tick();
            chk("reset_word", 32'(word), 32'h0);
            chk("reset_ro_rst", 32'(ro_rst), 32'h1);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0;
        repeat (4) tick();
        chk("idle_busy", 32'(busy), 32'h0);

        // Nominal word with alternating samples.
        fill_alt(16);
        pulse_start();
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_ro_rst", 32'(ro_rst), 32'h0);
        while (cyc - t0 < 17) tick();
        chk("collect_busy", 32'(busy), 32'h1);
        wait_valid(200);
        chk("valid_rise_cycle", 32'(cyc - t0), 32'd33);
        chk("word_aa", 32'(word), 32'hAA);
        chk("model_word_aa", 32'(model_word()), 32'hAA);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("valid_drop", 32'(valid), 32'h0);
        chk("drop_cycle", 32'(cyc - t0), 32'd34);
        wait_valid(200);
        chk("second_valid_cycle", 32'(cyc - t0), 32'd50);

        // Backpressure: word held for ten cycles, then a fresh word with no stale bits.
        held = word;
        repeat (10) tick();
        chk("bp_word_stable", 32'(word), 32'(held));
        chk("bp_valid_stable", 32'(valid), 32'h1);
        push_byte(8'h3C);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        wait_valid(200);
        chk("bp_next_word", 32'(word), 32'h3C);

        // Stuck-at-one source trips the repetition-count test.
        do_reset(1);
        stuck_en = 1'b1; stuck_val = 1'b1;
        drive_rand();
        pulse_start();
        wait_fail(200);
        chk("fail_cycle", 32'(cyc - t0), 32'd29);
        chk("fail_ro_rst", 32'(ro_rst), 32'h1);
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        chk("fail_sticky", 32'(fail), 32'h1);
        chk("fail_not_busy", 32'(busy), 32'h0);
        do_reset(1);
        chk("rst_clears_fail", 32'(fail), 32'h0);

        // Run of ones spanning a word boundary.
        push_byte(8'h57);
        push_byte(8'hE5);
        pulse_start();
        wait_valid(200);
        chk("xw_word", 32'(word), 32'h57);
        chk("xw_valid_cycle", 32'(cyc - t0), 32'd33);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        wait_fail(200);
        chk("xw_fail_cycle", 32'(cyc - t0), 32'd40);

        // Alternating stream never fails across 100 words.
        do_reset(1);
        fill_alt(900);
        ready = 1'b1;
        pulse_start();
        accepted = 0;
        for (int i = 0; i < 4000 && accepted < 100; i++) begin
            tick();
            if (valid) accepted++;
        end
        ready = 1'b0;
        chk("alt_words", 32'(accepted), 32'd100);
        chk("alt_no_fail", 32'(fail), 32'h0);

        // Stop during collect, restart with a full warm-up, start while busy ignored.
        do_reset(1);
        fill_alt(40);
        pulse_start();
        while (cyc - t0 < 25) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_ro_rst", 32'(ro_rst), 32'h1);
        chk("stop_busy", 32'(busy), 32'h0);
        while (cyc - t0 < 30) tick();
        src_q.delete();
        fill_alt(16);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'h1);
        while (cyc - t0 < 40) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(200);
        chk("restart_valid_cycle", 32'(cyc - t0), 32'd63);
        chk("restart_word", 32'(word), 32'hAA);

        // Randomized traffic against the model.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) begin
                stuck_en  = ~stuck_en;
                stuck_val = 1'($urandom_range(0, 1));
            end
            tick();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
